// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared FSM type, counter width and index-width helpers for apb_slave_mem
package apb_slv_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int CNT_W = 4;
  function automatic int idx_w(input int mem_depth);
    return $clog2(mem_depth);
  endfunction
  function automatic int lane_sh(input int strb_size);
    return $clog2(strb_size);
  endfunction
endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB request/response bundle between master and memory completer
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_SIZE = DATA_WIDTH / 8
);
  logic sel;
  logic enable;
  logic write;
  logic [STRB_SIZE-1:0] strobe;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic slverr;
  modport master(output sel, enable, write, strobe, addr, wdata, input ready, rdata, slverr);
  modport slave(input sel, enable, write, strobe, addr, wdata, output ready, rdata, slverr);
endinterface

// File: rtl/apb_slv_mem.sv
// apb_slv_mem: word array with synchronous clear, byte-lane writes and combinational read
module apb_slv_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_SIZE = DATA_WIDTH / 8,
  parameter int MEM_DEPTH = 16,
  parameter int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [IDX_W-1:0] idx,
  input  logic [STRB_SIZE-1:0] strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  // reset clears every word; otherwise only strobed lanes of the addressed word change
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    else if (we)
      for (int j = 0; j < STRB_SIZE; j++)
        if (strobe[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer over a register bank with WAIT_CYCLES wait states; APB_SLV_ERR_EN enables out-of-range slverr
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_SIZE = DATA_WIDTH / 8,
  parameter int MEM_DEPTH = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  apb_slave_mem_if.slave bus
);
  localparam int IDX_W = idx_w(MEM_DEPTH);
  localparam int LANE_SH = lane_sh(STRB_SIZE);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic write_q, oor_q;
  logic [STRB_SIZE-1:0] strobe_q;
  logic [IDX_W-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q, mem_rd;
  logic latch, ready, err, we;
  logic unused_ok;
  assign ready = state_q == ACCESS && cnt_q == CNT_W'(WAIT_CYCLES) && bus.sel && bus.enable;
`ifdef APB_SLV_ERR_EN
  assign err = oor_q;
`else
  assign err = 1'b0;
`endif
  assign unused_ok = ^{oor_q, bus.addr[LANE_SH-1:0]};
  assign we = ready && write_q && !err;
  assign bus.ready = ready;
  assign bus.slverr = ready && err;
  assign bus.rdata = (ready && !err) ? mem_rd : '0;
  // state, wait counter and the request captured during the setup phase
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      write_q <= 1'b0;
      oor_q <= 1'b0;
      strobe_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (latch) begin
        write_q <= bus.write;
        oor_q <= |bus.addr[ADDR_WIDTH-1:LANE_SH+IDX_W];
        strobe_q <= bus.strobe;
        idx_q <= bus.addr[LANE_SH +: IDX_W];
        wdata_q <= bus.wdata;
      end
    end
  // next state: setup enters ACCESS, deselect aborts, wait states count up, ready returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    latch = 1'b0;
    if (state_q == IDLE) begin
      latch = bus.sel && !bus.enable;
      state_d = latch ? ACCESS : IDLE;
      cnt_d = '0;
    end else if (!bus.sel)
      state_d = IDLE;
    else if (cnt_q != CNT_W'(WAIT_CYCLES))
      cnt_d = cnt_q + 1'b1;
    else if (ready)
      state_d = IDLE;
  end
  apb_slv_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_SIZE(STRB_SIZE),
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W(IDX_W)
  ) u_mem (
    .clk(clk),
    .rst(rst),
    .we(we),
    .idx(idx_q),
    .strobe(strobe_q),
    .wdata(wdata_q),
    .rdata(mem_rd)
  );
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed table, corner sequences and random traffic against a word-array model
module tb_apb_slave_mem;
`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic sel = 1'b0, enable = 1'b0, write = 1'b0;
  logic [3:0] strobe = '0;
  logic [31:0] addr = '0, wdata = '0;
  int dsel = 0;
  logic ready, slverr;
  logic [31:0] rdata;
  apb_slave_mem_if b0();
  apb_slave_mem_if b3();
  assign b0.sel = sel && dsel == 0;
  assign b3.sel = sel && dsel == 1;
  assign b0.enable = enable;
  assign b3.enable = enable;
  assign b0.write = write;
  assign b3.write = write;
  assign b0.strobe = strobe;
  assign b3.strobe = strobe;
  assign b0.addr = addr;
  assign b3.addr = addr;
  assign b0.wdata = wdata;
  assign b3.wdata = wdata;
  assign ready = dsel == 1 ? b3.ready : b0.ready;
  assign rdata = dsel == 1 ? b3.rdata : b0.rdata;
  assign slverr = dsel == 1 ? b3.slverr : b0.slverr;
  apb_slave_mem #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  apb_slave_mem #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  int total = 0, bad = 0;
  logic [31:0] mdl [2][16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic mdl_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask
  task automatic mdl_xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic err);
    int idx;
    idx = int'(a >> 2);
    err = ERR_EN && idx >= 16;
    rd = err ? 32'h0 : mdl[d][idx % 16];
    if (w && !err)
      for (int j = 0; j < 4; j++)
        if (st[j]) mdl[d][idx % 16][8*j +: 8] = wd[8*j +: 8];
  endtask
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int waits, output int rcyc);
    @(negedge clk);
    dsel = d;
    sel = 1'b1;
    enable = 1'b0;
    write = w;
    addr = a;
    wdata = wd;
    strobe = st;
    @(negedge clk);
    enable = 1'b1;
    waits = 0;
    #1;
    while (!ready && waits < 40) begin
      waits++;
      @(negedge clk);
      addr = $urandom;
      wdata = $urandom;
      write = 1'($urandom);
      strobe = 4'($urandom);
      #1;
    end
    rd = rdata;
    err = slverr;
    rcyc = cyc;
  endtask
  task automatic go_idle();
    @(negedge clk);
    sel = 1'b0;
    enable = 1'b0;
  endtask
  typedef struct {
    int d;
    bit w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] st;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t tv[$];
  initial begin
    logic [31:0] rd, erd, rd1;
    logic err, eerr;
    int waits, rc1, rc2;
    mdl_clear();
    tv.push_back('{0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0});
    tv.push_back('{0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{0, 1'b1, 32'h4, 32'h11223344, 4'hF, 32'h0, 1'b0});
    tv.push_back('{0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 32'h11223344, 1'b0});
    tv.push_back('{0, 1'b0, 32'h4, 32'h0, 4'hF, 32'h11BB33DD, 1'b0});
    tv.push_back('{0, 1'b1, 32'h6, 32'h0, 4'h0, 32'h11BB33DD, 1'b0});
    tv.push_back('{0, 1'b0, 32'h7, 32'h0, 4'h0, 32'h11BB33DD, 1'b0});
    tv.push_back('{1, 1'b1, 32'hC, 32'h12345678, 4'hF, 32'h0, 1'b0});
    tv.push_back('{1, 1'b0, 32'hC, 32'h0, 4'h0, 32'h12345678, 1'b0});
    if (ERR_EN) begin
      tv.push_back('{0, 1'b1, 32'h40, 32'h5, 4'hF, 32'h0, 1'b1});
      tv.push_back('{0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0});
      tv.push_back('{0, 1'b0, 32'h48, 32'h0, 4'h0, 32'h0, 1'b1});
    end else begin
      tv.push_back('{0, 1'b1, 32'h40, 32'h5, 4'hF, 32'h0, 1'b0});
      tv.push_back('{0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5, 1'b0});
      tv.push_back('{0, 1'b0, 32'h48, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("reset_idle", {ready, slverr, rdata[29:0]}, 32'h0);
    end
    for (int i = 0; i < tv.size(); i++) begin
      xfer(tv[i].d, tv[i].w, tv[i].a, tv[i].wd, tv[i].st, rd, err, waits, rc1);
      mdl_xfer(tv[i].d, tv[i].w, tv[i].a, tv[i].wd, tv[i].st, erd, eerr);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_slverr", i), 32'(err), 32'(tv[i].exp_err));
      chk($sformatf("vec%0d_waits", i), waits, tv[i].d == 1 ? 3 : 0);
    end
    @(negedge clk);
    dsel = 0;
    sel = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("enable_in_idle", 32'(ready), 32'h0);
    end
    xfer(0, 1'b1, 32'h0, 32'h1, 4'hF, rd1, err, waits, rc1);
    mdl_xfer(0, 1'b1, 32'h0, 32'h1, 4'hF, erd, eerr);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, waits, rc2);
    mdl_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eerr);
    chk("b2b_rdata", rd, 32'h1);
    chk("b2b_gap", rc2 - rc1, 2);
    go_idle();
    @(negedge clk);
    dsel = 1;
    sel = 1'b1;
    enable = 1'b0;
    write = 1'b1;
    addr = 32'hC;
    wdata = 32'hCAFEF00D;
    strobe = 4'hF;
    @(negedge clk);
    enable = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'h0);
    @(negedge clk);
    sel = 1'b0;
    enable = 1'b0;
    xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, err, waits, rc1);
    mdl_xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, erd, eerr);
    chk("abort_nowrite", rd, 32'h12345678);
    @(negedge clk);
    dsel = 1;
    sel = 1'b1;
    enable = 1'b0;
    write = 1'b1;
    addr = 32'hC;
    wdata = 32'h0BADF00D;
    strobe = 4'hF;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, err, waits, rc1);
    chk("rst_access_d3", rd, 32'h0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, waits, rc1);
    chk("rst_access_d0", rd, 32'h0);
    for (int i = 0; i < 80; i++) begin
      int d;
      bit w;
      logic [31:0] a, wd;
      logic [3:0] st;
      d = int'($urandom_range(0, 1));
      w = 1'($urandom);
      a = $urandom_range(0, 127);
      wd = $urandom;
      st = 4'($urandom);
      mdl_xfer(d, w, a, wd, st, erd, eerr);
      xfer(d, w, a, wd, st, rd, err, waits, rc1);
      chk($sformatf("rnd%0d_rdata a=%h", i, a), rd, erd);
      chk($sformatf("rnd%0d_slverr", i), 32'(err), 32'(eerr));
      chk($sformatf("rnd%0d_waits", i), waits, d == 1 ? 3 : 0);
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
